// File: rtl/midi_note_decoder.sv
// MIDI byte-stream parser: running status, channel filter and note decode,
// producing note_on/note_off strobes with a held note, velocity and waveform period.
module midi_note_decoder #(
  parameter int unsigned CLK_HZ  = 27000000,
  parameter logic [3:0]  CHANNEL = 4'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        note_on,
  output logic        note_off,
  output logic [31:0] period,
  output logic [6:0]  note,
  output logic [6:0]  velocity,
  output logic        active
);

  typedef enum logic [1:0] {NO_STATUS = 2'd0, WAIT_D1 = 2'd1, WAIT_D2 = 2'd2} state_t;

  // Top-octave (notes 120..131) frequencies in millihertz; lower octaves are left shifts.
  function automatic logic [31:0] top_period(input int k);
    logic [63:0] f_mhz;
    case (k)
      0:       f_mhz = 64'd8372018;
      1:       f_mhz = 64'd8869844;
      2:       f_mhz = 64'd9397273;
      3:       f_mhz = 64'd9956063;
      4:       f_mhz = 64'd10548082;
      5:       f_mhz = 64'd11175303;
      6:       f_mhz = 64'd11839822;
      7:       f_mhz = 64'd12543854;
      8:       f_mhz = 64'd13289750;
      9:       f_mhz = 64'd14080000;
      10:      f_mhz = 64'd14917240;
      default: f_mhz = 64'd15804266;
    endcase
    top_period = 32'((64'(CLK_HZ) * 64'd1000 + f_mhz / 64'd2) / f_mhz);
  endfunction

  localparam logic [31:0] PERIOD_TABLE [0:11] = '{
    top_period(0), top_period(1), top_period(2),  top_period(3),
    top_period(4), top_period(5), top_period(6),  top_period(7),
    top_period(8), top_period(9), top_period(10), top_period(11)
  };

  state_t      state, state_next;
  logic [7:0]  run_status, run_status_next;
  logic [6:0]  d1_hold, d1_hold_next;
  logic        msg_done;
  logic [6:0]  msg_d1, msg_d2;
  logic        one_byte, hit, dec_on, dec_off, dec_all;
  logic        s1_on, s1_off, s1_all;
  logic [6:0]  s1_note, s1_vel;
  logic [3:0]  oct, key;
  logic        s2_on, s2_off, s2_all;
  logic [6:0]  s2_note, s2_vel;
  logic [31:0] s2_period;

  assign one_byte = (run_status[7:5] == 3'b110);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= NO_STATUS;
      run_status <= 8'h00;
      d1_hold    <= 7'd0;
    end else begin
      state      <= state_next;
      run_status <= run_status_next;
      d1_hold    <= d1_hold_next;
    end
  end

  // Real-time bytes (F8..FF) fall through the first branch and leave everything untouched.
  always_comb begin
    state_next      = state;
    run_status_next = run_status;
    d1_hold_next    = d1_hold;
    if (rx_valid && rx_data[7]) begin
      if (rx_data[7:3] == 5'b11111) begin
        state_next = state;
      end else if (rx_data[7:4] == 4'hF) begin
        state_next      = NO_STATUS;
        run_status_next = 8'h00;
      end else begin
        state_next      = WAIT_D1;
        run_status_next = rx_data;
      end
    end else if (rx_valid) begin
      case (state)
        WAIT_D1: begin
          if (one_byte) begin
            state_next = WAIT_D1;
          end else begin
            state_next   = WAIT_D2;
            d1_hold_next = rx_data[6:0];
          end
        end
        WAIT_D2: state_next = WAIT_D1;
        default: state_next = NO_STATUS;
      endcase
    end else begin
      state_next = state;
    end
  end

  always_comb begin
    msg_done = 1'b0;
    msg_d1   = rx_data[6:0];
    msg_d2   = 7'd0;
    if (rx_valid && !rx_data[7]) begin
      case (state)
        WAIT_D1: msg_done = one_byte;
        WAIT_D2: begin
          msg_done = 1'b1;
          msg_d1   = d1_hold;
          msg_d2   = rx_data[6:0];
        end
        default: msg_done = 1'b0;
      endcase
    end else begin
      msg_done = 1'b0;
    end
  end

  assign hit     = msg_done && (run_status[3:0] == CHANNEL);
  assign dec_on  = hit && (run_status[7:4] == 4'h9) && (msg_d2 != 7'd0);
  assign dec_off = hit && ((run_status[7:4] == 4'h8) ||
                           ((run_status[7:4] == 4'h9) && (msg_d2 == 7'd0)));
  assign dec_all = hit && (run_status[7:4] == 4'hB) && (msg_d1 == 7'd123);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_on <= 1'b0; s1_off <= 1'b0; s1_all <= 1'b0;
      s1_note <= 7'd0; s1_vel <= 7'd0;
    end else begin
      s1_on <= dec_on; s1_off <= dec_off; s1_all <= dec_all;
      s1_note <= msg_d1; s1_vel <= msg_d2;
    end
  end

  assign oct = 4'(s1_note / 7'd12);
  assign key = 4'(s1_note % 7'd12);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_on <= 1'b0; s2_off <= 1'b0; s2_all <= 1'b0;
      s2_note <= 7'd0; s2_vel <= 7'd0; s2_period <= 32'd0;
    end else begin
      s2_on <= s1_on; s2_off <= s1_off; s2_all <= s1_all;
      s2_note <= s1_note; s2_vel <= s1_vel;
      s2_period <= PERIOD_TABLE[key] << (4'd10 - oct);
    end
  end

  // Note-off only releases the note that is actually sounding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      note_on <= 1'b0; note_off <= 1'b0; active <= 1'b0;
      period <= 32'd0; note <= 7'd0; velocity <= 7'd0;
    end else begin
      note_on  <= 1'b0;
      note_off <= 1'b0;
      if (s2_on) begin
        note_on  <= 1'b1;
        active   <= 1'b1;
        note     <= s2_note;
        velocity <= s2_vel;
        period   <= s2_period;
      end else if (active && (s2_all || (s2_off && (s2_note == note)))) begin
        note_off <= 1'b1;
        active   <= 1'b0;
      end else begin
        active <= active;
      end
    end
  end

endmodule

// File: doc/midi_note_decoder.md
# midi_note_decoder

Monophonic MIDI front end that parses a serial-received MIDI byte stream and drives the note-control side of the voice: `note_on`/`note_off` strobes plus a held `period`, note number and velocity. Sits between the UART receiver (byte + valid strobe) and the `notebank` voice inputs (`note_on`, `note_off`, `period`). Handles running status, channel filtering, velocity-0 note-off, All-Notes-Off, and real-time/system bytes.

## Interface
- `CLK_HZ`, default 27000000: system clock rate; sets the period table.
- `CHANNEL`, default 4'd0: MIDI channel accepted (0..15).
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `rx_data`  in  8  received MIDI byte.
- `rx_valid`  in  1  one-cycle strobe; `rx_data` valid this cycle.
- `note_on`  out  1  one-cycle pulse: new note started or retriggered.
- `note_off`  out  1  one-cycle pulse: current note released.
- `period`  out  32  waveform period of current note, in `clk` cycles; held.
- `note`  out  7  current note number; held.
- `velocity`  out  7  current note-on velocity; held.
- `active`  out  1  high while a note is sounding.

## Operation
- Byte classes: status = bit7 set; data = bit7 clear.
- Real-time (0xF8-0xFF): ignored entirely; parser state, running status and partial message untouched.
- System common/SysEx (0xF0-0xF7): clears running status; state -> NO_STATUS; following data bytes ignored.
- Channel status (0x80-0xEF): latched as running status; state -> WAIT_D1. Message length: 0xCn/0xDn = 1 data byte, others = 2.
- Parser states: NO_STATUS (data bytes dropped), WAIT_D1, WAIT_D2.
  - WAIT_D1 + data: 1-byte message -> complete, stay WAIT_D1; else latch d1, -> WAIT_D2.
  - WAIT_D2 + data: message complete, -> WAIT_D1 (running status).
  - Any channel status byte mid-message aborts the partial message, restarts at WAIT_D1.
- Completed messages with channel != `CHANNEL` discarded.
- Note On (0x9n, vel>0): load `note`, `velocity`, `period`; pulse `note_on`; `active`=1. Retriggers even if same or other note already active.
- Note Off (0x8n any vel, or 0x9n vel=0): if `active` and d1 == `note` -> pulse `note_off`, `active`=0; otherwise no effect. `note`/`velocity`/`period` hold.
- Control Change 0xBn with d1=123: if `active`, pulse `note_off`, `active`=0.
- All other messages: no output effect.
- Period: k = n mod 12, oct = n div 12 (0..10). Table entry T[k] = round(CLK_HZ / f(120+k)), f(m) = 440*2^((m-69)/12), constants computed at elaboration. `period` = T[k] << (10 - oct). Zero-extended to 32 bits; no overflow for n=0..127 at CLK_HZ <= 100 MHz.

## Timing
- Reset (async assert, sync release): all outputs 0, state NO_STATUS, running status cleared.
- Latency: final data byte sampled at cycle T -> `note_on`/`note_off` pulse at T+2; `note`, `velocity`, `period`, `active` update in the same cycle as the pulse (one internal stage for div/mod and table shift).
- Pulses exactly one cycle wide; never both in the same cycle.
- Fully pipelined: `rx_valid` on consecutive cycles accepted; no back-pressure, no byte ever dropped except by rule above.
- Reset asserted with a message in the pipeline: message discarded, no pulse after release.

## Test plan
- 0x90,0x45,0x64 -> at T+2 single `note_on`; `note`=69, `velocity`=100, `period`=61376 (1918<<5), `active`=1.
- Running status: 0x90,0x3C,0x40 then 0x3C,0x00 -> `note_on` with `period`=103200 (3225<<5), then one `note_off`, `active`=0, `note` holds 60.
- 0x90,0x3C,0x40, 0x90,0x40,0x40, 0x80,0x3C,0x00 -> two `note_on`, no `note_off`, `note`=64, `active`=1; then 0xB0,0x7B,0x00 -> `note_off`.
- 0x90,0xF8,0x3C,0xFE,0x40 (real-time interleaved) -> identical to 0x90,0x3C,0x40; `note_on` 2 cycles after last byte.
- 0x91,0x3C,0x40 with CHANNEL=0 -> no pulse; 0xF0,0x3C,0x40,0xF7,0x3C,0x40 after reset -> no pulse; 0xC0,0x05,0x90 then 0x45,0x7F -> single `note_on`, `note`=69.
- 0x90,0x45 then `rst` mid-message, release, 0x40 -> no pulse, outputs remain 0.
